// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding,
// PC width, reset PC default and the wrapping PC increment.
package fetch_pkg;

    localparam int          PC_W           = 16;
    localparam logic [15:0] FETCH_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH_LO = 2'd1,
        ST_FETCH_HI = 2'd2,
        ST_DONE     = 2'd3
    } fetch_state_t;

    // PC advance wraps modulo 2^16; the carry out is deliberately dropped.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Fetches one 16-bit little-endian instruction as two byte reads from
// instruction memory, steering each byte into the matching half of the IR.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic        Flush,
    input  logic        PCLoad,
    input  logic [15:0] PCIn,
    input  logic [7:0]  MemData,
    input  logic        MemReady,
    output logic [15:0] MemAddr,
    output logic        MemRead,
    output logic [7:0]  I,
    output logic        LH,
    output logic        Write,
    output logic [15:0] PC,
    output logic        Busy,
    output logic        Done
);

    fetch_state_t      state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;

    // State and PC registers; reset abandons any fetch immediately.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state, PC update and all outputs. Outputs are decoded from the
    // registered state so reset clears them without waiting for a clock.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        MemRead = 1'b0;
        Write   = 1'b0;
        LH      = 1'b0;
        Busy    = 1'b0;
        Done    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                Done = (state_q == ST_DONE);
                // Flush wins over Start and keeps PC untouched, including
                // any jump target presented in the same cycle.
                if (Flush) begin
                    state_d = ST_IDLE;
                end else begin
                    if (PCLoad)
                        pc_d = PCIn;
                    state_d = Start ? ST_FETCH_LO : ST_IDLE;
                end
            end
            ST_FETCH_LO, ST_FETCH_HI: begin
                // Start and PCLoad are ignored while a fetch is in flight.
                MemRead = 1'b1;
                Busy    = 1'b1;
                LH      = (state_q == ST_FETCH_HI);
                if (Flush) begin
                    state_d = ST_IDLE;
                end else if (MemReady) begin
                    Write   = 1'b1;
                    pc_d    = pc_inc(pc_q);
                    state_d = (state_q == ST_FETCH_LO) ? ST_FETCH_HI : ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign MemAddr = MemRead ? pc_q : '0;
    assign I       = MemData;
    assign PC      = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_fetch_sequencer;

    localparam logic [15:0] RPC = 16'h0000;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        Start, Flush, PCLoad, MemReady;
    logic [15:0] PCIn;
    logic [7:0]  MemData;
    logic [15:0] MemAddr, PC;
    logic        MemRead, LH, Write, Busy, Done;
    logic [7:0]  I;

    int n_chk  = 0;
    int n_fail = 0;

    fetch_sequencer #(.RESET_PC(RPC)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Flush(Flush),
        .PCLoad(PCLoad), .PCIn(PCIn), .MemData(MemData), .MemReady(MemReady),
        .MemAddr(MemAddr), .MemRead(MemRead), .I(I), .LH(LH), .Write(Write),
        .PC(PC), .Busy(Busy), .Done(Done)
    );

    always #5 Clock = ~Clock;

    // Instruction register attached to the sequencer's byte-write port.
    logic [15:0] ir = 16'h0000;
    always @(posedge Clock) begin
        if (Write) begin
            if (LH) ir[15:8] <= I;
            else    ir[7:0]  <= I;
        end
    end

    // Transaction-level model: is a fetch active, how many bytes of it have
    // landed, has a full instruction just completed, and where PC points.
    bit          m_active;
    int          m_bytes;
    bit          m_done;
    logic [15:0] m_pc;
    logic [15:0] m_ir;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_bytes = 0; m_done = 0; m_pc = RPC;
    endtask

    task automatic model_check();
        bit ew;
        ew = m_active && MemReady && !Flush;
        chk("m_memread", MemRead, m_active);
        chk("m_busy",    Busy,    m_active);
        chk("m_memaddr", MemAddr, m_active ? m_pc : 16'h0);
        chk("m_write",   Write,   ew);
        chk("m_lh",      LH,      m_active && m_bytes == 1);
        chk("m_done",    Done,    m_done);
        chk("m_pc",      PC,      m_pc);
        chk("m_i",       I,       MemData);
        if (m_done) chk("m_ir", ir, m_ir);
    endtask

    task automatic model_update();
        if (!Reset_n) begin
            model_reset();
        end else if (Flush) begin
            m_active = 0; m_done = 0;
        end else if (m_active) begin
            if (MemReady) begin
                if (m_bytes == 0) m_ir[7:0] = MemData;
                else              m_ir[15:8] = MemData;
                m_pc = m_pc + 16'd1;
                m_bytes++;
                if (m_bytes == 2) begin
                    m_active = 0; m_done = 1;
                end
            end
        end else begin
            m_done = 0;
            if (PCLoad) m_pc = PCIn;
            if (Start) begin
                m_active = 1; m_bytes = 0;
            end
        end
    endtask

    task automatic at_neg();
        @(negedge Clock);
        model_check();
    endtask

    task automatic at_pos();
        @(posedge Clock);
        model_update();
        #1;
    endtask

    task automatic step();
        at_neg();
        at_pos();
    endtask

    task automatic drive(input bit s, input bit f, input bit l, input logic [15:0] pin,
                         input bit r, input logic [7:0] d);
        Start = s; Flush = f; PCLoad = l; PCIn = pin; MemReady = r; MemData = d;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        model_reset();
        drive(0, 0, 0, 16'h0, 0, 8'h0);
        at_neg();
        at_pos();
        Reset_n = 1'b1;
    endtask

    typedef struct {
        logic        start, ready;
        logic [7:0]  data;
        logic        w, lh, mr, busy, done;
        logic [15:0] pc;
    } vec_t;

    vec_t tbl[12];

    initial begin
        // Basic fetch of 0x1234, then a fetch with a 3-cycle stall in FETCH_HI.
        //            st rdy data    w  lh mr bsy dn pc
        tbl[0]  = '{1, 0, 8'h00,  0, 0, 0, 0, 0, 16'h0000};
        tbl[1]  = '{0, 1, 8'h34,  1, 0, 1, 1, 0, 16'h0000};
        tbl[2]  = '{0, 1, 8'h12,  1, 1, 1, 1, 0, 16'h0001};
        tbl[3]  = '{0, 0, 8'h00,  0, 0, 0, 0, 1, 16'h0002};
        tbl[4]  = '{0, 0, 8'h00,  0, 0, 0, 0, 0, 16'h0002};
        tbl[5]  = '{1, 0, 8'h00,  0, 0, 0, 0, 0, 16'h0002};
        tbl[6]  = '{0, 1, 8'hCD,  1, 0, 1, 1, 0, 16'h0002};
        tbl[7]  = '{0, 0, 8'h11,  0, 1, 1, 1, 0, 16'h0003};
        tbl[8]  = '{0, 0, 8'h22,  0, 1, 1, 1, 0, 16'h0003};
        tbl[9]  = '{0, 0, 8'h33,  0, 1, 1, 1, 0, 16'h0003};
        tbl[10] = '{0, 1, 8'hAB,  1, 1, 1, 1, 0, 16'h0003};
        tbl[11] = '{0, 0, 8'h00,  0, 0, 0, 0, 1, 16'h0004};

        Reset_n = 1'b0;
        drive(0, 0, 0, 16'h0, 0, 8'h0);
        model_reset();
        #3;
        chk("rst_write", Write, 0);
        chk("rst_memread", MemRead, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_lh", LH, 0);
        chk("rst_pc", PC, RPC);
        at_neg();
        at_pos();
        Reset_n = 1'b1;

        // Directed table.
        for (int k = 0; k < 12; k++) begin
            drive(tbl[k].start, 0, 0, 16'h0, tbl[k].ready, tbl[k].data);
            at_neg();
            chk($sformatf("tbl%0d_write", k), Write, tbl[k].w);
            chk($sformatf("tbl%0d_lh", k), LH, tbl[k].lh);
            chk($sformatf("tbl%0d_memread", k), MemRead, tbl[k].mr);
            chk($sformatf("tbl%0d_busy", k), Busy, tbl[k].busy);
            chk($sformatf("tbl%0d_done", k), Done, tbl[k].done);
            chk($sformatf("tbl%0d_pc", k), PC, tbl[k].pc);
            if (k == 3)  chk("ir_1234", ir, 16'h1234);
            if (k == 11) chk("ir_abcd", ir, 16'hABCD);
            at_pos();
        end

        // Jump to 0xFFFF and fetch across the wrap.
        drive(1, 0, 1, 16'hFFFF, 0, 8'h00);
        step();
        drive(0, 0, 0, 16'h0, 1, 8'h5A);
        #1 chk("wrap_addr_lo", MemAddr, 16'hFFFF);
        step();
        drive(0, 0, 0, 16'h0, 1, 8'hA5);
        #1 chk("wrap_addr_hi", MemAddr, 16'h0000);
        step();
        drive(0, 0, 0, 16'h0, 0, 8'h00);
        #1 chk("wrap_pc", PC, 16'h0001);
        chk("wrap_ir", ir, 16'hA55A);
        step();

        // Flush in FETCH_HI: no high-byte write, back to idle, PC = start+1.
        drive(1, 0, 1, 16'h1000, 0, 8'h00);
        step();
        drive(0, 0, 0, 16'h0, 1, 8'h77);
        step();
        drive(1, 1, 0, 16'h0, 1, 8'h88);
        #1 chk("flush_write", Write, 0);
        step();
        drive(0, 0, 0, 16'h0, 0, 8'h00);
        #1 chk("flush_busy", Busy, 0);
        chk("flush_done", Done, 0);
        chk("flush_pc", PC, 16'h1001);
        step();
        step();
        chk("flush_done2", Done, 0);

        // Asynchronous reset between edges while in FETCH_LO.
        drive(1, 0, 0, 16'h0, 0, 8'h00);
        step();
        drive(0, 0, 0, 16'h0, 0, 8'h00);
        #2 Reset_n = 1'b0;
        #1;
        chk("arst_memread", MemRead, 0);
        chk("arst_busy", Busy, 0);
        chk("arst_write", Write, 0);
        chk("arst_pc", PC, RPC);
        model_reset();
        at_neg();
        at_pos();
        Reset_n = 1'b1;
        drive(0, 0, 0, 16'h0, 1, 8'hEE);
        for (int k = 0; k < 3; k++) step();

        // Start held high: back-to-back fetches, PCLoad in FETCH_LO ignored.
        drive(1, 0, 0, 16'h0, 1, 8'h01);
        step();
        drive(1, 0, 1, 16'h4000, 1, 8'h02);
        step();
        drive(1, 0, 0, 16'h0, 1, 8'h03);
        step();
        #1 chk("b2b_done", Done, 1);
        step();
        #1 chk("b2b_busy", Busy, 1);
        chk("b2b_pc", PC, RPC + 16'd2);
        step();
        step();
        step();
        chk("b2b_pc2", PC, RPC + 16'd4);

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 2000; k++) begin
            drive($urandom_range(0, 1), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 4) == 0), 16'($urandom),
                  ($urandom_range(0, 9) < 6), 8'($urandom));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
